// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM PIO: register map and edge-capture modes.
package avalon_pio_pkg;
  localparam int NUM_REGS = 8;

  localparam logic [2:0] ADDR_OUT      = 3'd0;
  localparam logic [2:0] ADDR_IN       = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;
endpackage

// File: rtl/pio_edge_detect.sv
// Input synchroniser plus edge detector, gated until the synchroniser has
// flushed its reset-zero contents so a high input at reset is not seen as an edge.
module pio_edge_detect
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_value,
  output logic [WIDTH-1:0] edge_pulse
);
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int CW      = $clog2(ARM_MAX + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [CW-1:0]                     arm_cnt;
  logic                              armed;
  logic [WIDTH-1:0]                  raw_edge;

  assign sync_value = sync_q[SYNC_STAGES-1];
  assign armed      = (arm_cnt == CW'(ARM_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      arm_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q <= sync_value;
      if (!armed) arm_cnt <= arm_cnt + CW'(1);
    end
  end

  generate
    if (EDGE_TYPE == EDGE_RISING) begin : g_rise
      assign raw_edge = sync_value & ~prev_q;
    end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
      assign raw_edge = ~sync_value & prev_q;
    end else begin : g_any
      assign raw_edge = sync_value ^ prev_q;
    end
  endgenerate

  assign edge_pulse = armed ? raw_edge : '0;
endmodule

// File: rtl/avalon_pio_gen.sv
// Avalon-MM PIO: output register with atomic set/clear, synchronised input,
// sticky W1C edge capture and a maskable level interrupt.
module avalon_pio_gen
  import avalon_pio_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync_value;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] w1c_bits;
  logic             wr_en;

  pio_edge_detect #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .sync_value(sync_value),
    .edge_pulse(edge_pulse)
  );

  assign wr_en    = chipselect & ~write_n;
  assign w1c_bits = (wr_en && address == ADDR_EDGE_CAP) ? writedata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg  <= RESET_VALUE;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_OUT:      out_reg  <= writedata;
          ADDR_OUTSET:   out_reg  <= out_reg | writedata;
          ADDR_OUTCLR:   out_reg  <= out_reg & ~writedata;
          ADDR_IRQ_MASK: irq_mask <= writedata;
          default: ;
        endcase
      end
      // A fresh edge wins over a simultaneous clear of the same bit.
      edge_cap <= (edge_cap & ~w1c_bits) | edge_pulse;
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_OUT:      readdata = out_reg;
        ADDR_IN:       readdata = sync_value;
        ADDR_IRQ_MASK: readdata = irq_mask;
        ADDR_EDGE_CAP: readdata = edge_cap;
        default:       readdata = '0;
      endcase
    end
  end

  assign out_port = out_reg;
  assign irq      = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_avalon_pio_gen.sv
// Directed bench: a rising-edge instance (non-zero reset value) and an any-edge
// instance share the bus; each has its own in_port.
module tb_avalon_pio_gen;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic        write_n;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] in_a, in_b, rd_a, rd_b, out_a, out_b;
  logic        irq_a, irq_b;
  logic [31:0] va, vb;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  avalon_pio_gen #(.WIDTH(32), .RESET_VALUE(32'hA5A5_0000), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .out_port(out_a), .irq(irq_a)
  );

  avalon_pio_gen #(.WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_b), .out_port(out_b), .irq(irq_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] ra, output logic [31:0] rb);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    #1;
    ra = rd_a; rb = rd_b;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    in_a = '0; in_b = '1;
    repeat (3) tick();
    checks++; if (out_a !== 32'hA5A5_0000) begin failures++; $display("FAIL reset_out_a got=%h exp=%h", out_a, 32'hA5A5_0000); end
    checks++; if (out_b !== 32'h0) begin failures++; $display("FAIL reset_out_b got=%h exp=%h", out_b, 32'h0); end
    checks++; if (irq_a !== 1'b0 || irq_b !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b%b exp=00", irq_a, irq_b); end
    checks++; if (rd_a !== 32'h0) begin failures++; $display("FAIL reset_rd_nocs got=%h exp=0", rd_a); end
    rd(3'd0, va, vb);
    checks++; if (va !== 32'hA5A5_0000) begin failures++; $display("FAIL reset_rd_out got=%h exp=%h", va, 32'hA5A5_0000); end
    rd(3'd3, va, vb);
    checks++; if (va !== 32'h0 || vb !== 32'h0) begin failures++; $display("FAIL reset_rd_edge got=%h/%h exp=0/0", va, vb); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_arm();
    for (int i = 0; i < 8; i++) begin
      tick();
      rd(3'd3, va, vb);
      checks++; if (vb !== 32'h0) begin failures++; $display("FAIL arm_edge_cap cyc=%0d got=%h exp=0", i, vb); end
    end
    rd(3'd1, va, vb);
    checks++; if (vb !== 32'hFFFF_FFFF) begin failures++; $display("FAIL arm_in_b got=%h exp=ffffffff", vb); end
  endtask

  task automatic test_set_clr();
    wr(3'd0, 32'h0000_00F0);
    checks++; if (out_a !== 32'hF0 || out_b !== 32'hF0) begin failures++; $display("FAIL setclr_out got=%h/%h exp=f0", out_a, out_b); end
    wr(3'd4, 32'h0000_000F);
    checks++; if (out_a !== 32'hFF) begin failures++; $display("FAIL setclr_set got=%h exp=ff", out_a); end
    wr(3'd5, 32'h0000_0030);
    checks++; if (out_a !== 32'hCF) begin failures++; $display("FAIL setclr_clr got=%h exp=cf", out_a); end
    rd(3'd0, va, vb);
    checks++; if (va !== 32'hCF) begin failures++; $display("FAIL setclr_rd got=%h exp=cf", va); end
  endtask

  task automatic test_rise_capture();
    wr(3'd2, 32'h1);
    in_a = 32'h1;
    tick();
    rd(3'd1, va, vb);
    checks++; if (va !== 32'h0) begin failures++; $display("FAIL rise_in_early got=%h exp=0", va); end
    tick();
    rd(3'd1, va, vb);
    checks++; if (va !== 32'h1) begin failures++; $display("FAIL rise_in got=%h exp=1", va); end
    rd(3'd3, va, vb);
    checks++; if (va !== 32'h0 || irq_a !== 1'b0) begin failures++; $display("FAIL rise_cap_early got=%h irq=%b exp=0/0", va, irq_a); end
    tick();
    rd(3'd3, va, vb);
    checks++; if (va !== 32'h1 || irq_a !== 1'b1) begin failures++; $display("FAIL rise_cap got=%h irq=%b exp=1/1", va, irq_a); end
    wr(3'd3, 32'h1);
    rd(3'd3, va, vb);
    checks++; if (va !== 32'h0 || irq_a !== 1'b0) begin failures++; $display("FAIL rise_w1c got=%h irq=%b exp=0/0", va, irq_a); end
  endtask

  task automatic test_back_to_back_w1c();
    in_a = 32'h2;
    repeat (3) tick();
    rd(3'd3, va, vb);
    checks++; if (va !== 32'h2 || irq_a !== 1'b0) begin failures++; $display("FAIL simul_pre got=%h irq=%b exp=2/0", va, irq_a); end
    in_a = 32'h3;
    tick();
    tick();
    wr(3'd3, 32'h3);
    rd(3'd3, va, vb);
    checks++; if (va !== 32'h1 || irq_a !== 1'b1) begin failures++; $display("FAIL simul_w1c got=%h irq=%b exp=1/1", va, irq_a); end
    wr(3'd3, 32'h1);
    rd(3'd3, va, vb);
    checks++; if (va !== 32'h0) begin failures++; $display("FAIL simul_clear got=%h exp=0", va); end
  endtask

  task automatic test_any_fall();
    in_b = 32'hFFFF_FFF7;
    tick();
    tick();
    rd(3'd3, va, vb);
    checks++; if (vb !== 32'h0) begin failures++; $display("FAIL fall_early got=%h exp=0", vb); end
    tick();
    rd(3'd3, va, vb);
    checks++; if (vb !== 32'h8 || irq_b !== 1'b0) begin failures++; $display("FAIL fall_cap got=%h irq=%b exp=8/0", vb, irq_b); end
    rd(3'd1, va, vb);
    checks++; if (vb !== 32'hFFFF_FFF7) begin failures++; $display("FAIL fall_in got=%h exp=fffffff7", vb); end
    wr(3'd3, 32'h8);
  endtask

  task automatic test_mask();
    wr(3'd2, 32'h0);
    in_a = 32'h23;
    repeat (3) tick();
    rd(3'd3, va, vb);
    checks++; if (va !== 32'h20 || irq_a !== 1'b0) begin failures++; $display("FAIL mask_off got=%h irq=%b exp=20/0", va, irq_a); end
    wr(3'd2, 32'h20);
    checks++; if (irq_a !== 1'b1) begin failures++; $display("FAIL mask_on_irq got=%b exp=1", irq_a); end
    rd(3'd3, va, vb);
    checks++; if (va !== 32'h20) begin failures++; $display("FAIL mask_keep_cap got=%h exp=20", va); end
    rd(3'd6, va, vb);
    checks++; if (va !== 32'h0 || vb !== 32'h0) begin failures++; $display("FAIL rd_addr6 got=%h/%h exp=0", va, vb); end
    tick();
    rd(3'd7, va, vb);
    checks++; if (va !== 32'h0) begin failures++; $display("FAIL rd_addr7 got=%h exp=0", va); end
    rd(3'd4, va, vb);
    checks++; if (va !== 32'h0) begin failures++; $display("FAIL rd_outset got=%h exp=0", va); end
    rd(3'd5, va, vb);
    checks++; if (va !== 32'h0) begin failures++; $display("FAIL rd_outclr got=%h exp=0", va); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_a !== 32'hA5A5_0000 || irq_a !== 1'b0) begin failures++; $display("FAIL midrst_out got=%h irq=%b exp=a5a50000/0", out_a, irq_a); end
    rd(3'd3, va, vb);
    checks++; if (va !== 32'h0) begin failures++; $display("FAIL midrst_cap got=%h exp=0", va); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      rd(3'd3, va, vb);
      checks++; if (va !== 32'h0 || vb !== 32'h0) begin failures++; $display("FAIL midrst_rearm cyc=%0d got=%h/%h exp=0/0", i, va, vb); end
    end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_set_clr();
    test_rise_capture();
    test_back_to_back_w1c();
    test_any_fall();
    test_mask();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/avalon_pio_gen.md
Name: avalon_pio_gen

Overview:
- Parametrised Avalon-MM slave general-purpose I/O block, the next generation of the team's single-register output PIO.
- Adds the following to the plain output register:
  - atomic set/clear writes,
  - a synchronised input port,
  - per-bit edge capture with write-1-to-clear,
  - a maskable level interrupt to the Nios II.
- Sits on the system interconnect between the CPU data master and FPGA fabric control/status signals.

Parameters:
- WIDTH, 32: data width of out_port, in_port, readdata, writedata (1..32).
- RESET_VALUE, 0: value loaded into the output register on reset (WIDTH bits).
- EDGE_TYPE, 0: edge capture mode. 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2: synchroniser depth on in_port (2..4).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register select (word address).
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  WIDTH  write data.
- readdata  out  WIDTH  read data, combinational, zero wait states.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  output register contents.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset: reset_n is asynchronous and active-low; clock is clk.
  - out_reg = RESET_VALUE. irq_mask = 0. edge_cap = 0.
  - Synchroniser flops and prev-sample = 0. arm counter = 0.
  - out_port = RESET_VALUE, irq = 0, readdata = 0 unless addressed.
- A write occurs on a rising clk edge when chipselect = 1 and write_n = 0. Writes take effect on that edge; the new value is visible in the next cycle.
- Register map:
  - 0 OUT (RW): write loads out_reg; read returns out_reg.
  - 1 IN (RO): read returns the synchronised input; writes are ignored.
  - 2 IRQ_MASK (RW): per-bit interrupt enable.
  - 3 EDGE_CAP (R/W1C): read returns edge_cap; write clears every bit set in writedata.
  - 4 OUTSET (WO): out_reg <= out_reg | writedata.
  - 5 OUTCLR (WO): out_reg <= out_reg & ~writedata.
  - 6, 7: reserved. Reads return 0; writes are ignored.
  - Reads of OUTSET/OUTCLR return 0.
- readdata is combinational from address and the registers. It is 0 when chipselect = 0.
- Synchroniser: in_port passes through a SYNC_STAGES flop chain. The IN register reflects an in_port change SYNC_STAGES edges after it is first sampled.
- Edge detect compares the synchroniser output with a one-cycle delayed copy:
  - rising: sync & ~prev.
  - falling: ~sync & prev.
  - any: sync ^ prev.
- edge_cap bit sets on the edge after the synchronised change, i.e. SYNC_STAGES+1 edges after sampling. The bit is sticky until cleared.
- Arming after reset:
  - A saturating counter suppresses edge capture until SYNC_STAGES+1 edges have elapsed after reset_n deasserts.
  - This prevents a false capture from the reset-zero synchroniser state when in_port is high at reset.
- irq = |(edge_cap & irq_mask), combinational from registers. It asserts in the same cycle the edge_cap bit becomes 1.
- Simultaneous events:
  - W1C and a new edge on the same bit in the same cycle: the set wins and the bit stays 1.
  - W1C on other bits is unaffected by the edge.
- Writing IRQ_MASK does not alter edge_cap. Unmasking an already-captured bit raises irq in the next cycle.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). The arm counter restarts.

Decomposition:
- Package avalon_pio_pkg:
  - Address constants ADDR_OUT..ADDR_OUTCLR.
  - EDGE_RISING / EDGE_FALLING / EDGE_ANY constants.
  - Register count.
- Sub-module pio_edge_detect contains the synchroniser, prev register, arm counter and edge-mode selection.
  - Parameters: WIDTH, SYNC_STAGES, EDGE_TYPE.
  - Outputs: sync_value[WIDTH], edge_pulse[WIDTH].
- The top level keeps the register file, W1C/set logic, read mux and irq.

Test Plan:
- Reset with RESET_VALUE = 32'hA5A5_0000 -> out_port = A5A50000, irq = 0, read of addr 0 = A5A50000, read of addr 3 = 0.
- Set/clear: write 0 = 32'h0000_00F0, then write 4 = 32'h0000_000F, then write 5 = 32'h0000_0030 -> out_port = F0, then FF, then CF, each one cycle after its write.
- Rising capture, SYNC_STAGES = 2, mask = 1:
  - Drive in_port bit0 0->1 before edge N -> IN bit0 = 1 after edge N+1, edge_cap bit0 = 1 and irq = 1 after edge N+2.
  - Write 3 = 1 -> irq = 0 the next cycle.
- Simultaneous W1C of bit0 and a new rising edge on bit0 in the same cycle -> edge_cap bit0 stays 1, irq stays 1.
- Hold in_port = 32'hFFFF_FFFF through reset release -> edge_cap remains 0 for all cycles; then a falling edge with EDGE_TYPE = 2 sets the corresponding bit.
- Mask test: capture on bit5 with mask = 0 -> irq = 0. Write mask = 32'h20 -> irq = 1 the next cycle. Read 6/7 -> 0.
